// File: rtl/sram_1rw1r_initiator_if.sv
// Handshake bundle between the user datapath and sram_1rw1r_initiator:
// port-0 command/response streams and the port-1 scan request/data streams.
interface sram_1rw1r_initiator_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_WMASKS = 1
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [NUM_WMASKS-1:0] cmd_wmask;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    logic                  scan_start;
    logic [ADDR_WIDTH-1:0] scan_base;
    logic [ADDR_WIDTH:0]   scan_len;
    logic                  scan_busy;
    logic                  scan_done;
    logic                  scan_valid;
    logic                  scan_ready;
    logic [DATA_WIDTH-1:0] scan_data;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wmask,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata,
        output rsp_ready,
        output scan_start, scan_base, scan_len, scan_ready,
        input  scan_busy, scan_done, scan_valid, scan_data
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wmask,
        output cmd_ready,
        output rsp_valid, rsp_rdata,
        input  rsp_ready,
        input  scan_start, scan_base, scan_len, scan_ready,
        output scan_busy, scan_done, scan_valid, scan_data
    );
endinterface

// File: rtl/sram_1rw1r_initiator.sv
// Initiator for one OpenRAM 1rw1r macro: port-0 read/write commands and a port-1 sequential scan.
// Optional macro SRAM_INITIATOR_COLLISION_STALL_EN holds a scan read that hits a same-cycle port-0 write.

module sram_1rw1r_initiator_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk0,
    input  logic             rst0,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] mem [2];
    logic             wptr;
    logic             rptr;

    assign dout = mem[rptr];

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end
endmodule

module sram_1rw1r_initiator #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_WMASKS = 1
) (
    input  logic                  clk0,
    input  logic                  rst0,
    sram_1rw1r_initiator_if.slave bus,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic                  rd0_s1, rd0_s2;
    logic [1:0]            rsp_count;
    logic [DATA_WIDTH-1:0] rsp_dout;
    logic [2:0]            credit0;
    logic                  cmd_fire, rsp_pop;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] scan_addr;
    logic [ADDR_WIDTH:0]   issue_left, accept_left, eff_len;
    logic                  rd1_s1, rd1_s2;
    logic [1:0]            scan_count;
    logic [DATA_WIDTH-1:0] scan_dout;
    logic [2:0]            credit1;
    logic                  collide, scan_issue, scan_pop, scan_done_q;

    // A read holds a credit from acceptance until its word leaves the FIFO,
    // so the 2-entry FIFO can never overflow.
    assign credit0       = {2'b00, rd0_s1} + {2'b00, rd0_s2} + {1'b0, rsp_count};
    assign bus.cmd_ready = (credit0 < 3'd2);
    assign cmd_fire      = bus.cmd_valid & bus.cmd_ready;
    assign bus.rsp_valid = (rsp_count != 2'd0);
    assign bus.rsp_rdata = rsp_dout;
    assign rsp_pop       = bus.rsp_valid & bus.rsp_ready;

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= '0;
            addr0  <= '0;
            din0   <= '0;
            rd0_s1 <= 1'b0;
            rd0_s2 <= 1'b0;
        end else begin
            rd0_s1 <= cmd_fire & ~bus.cmd_we;
            rd0_s2 <= rd0_s1;
            if (cmd_fire) begin
                csb0   <= 1'b0;
                web0   <= ~bus.cmd_we;
                wmask0 <= bus.cmd_we ? bus.cmd_wmask : '0;
                addr0  <= bus.cmd_addr;
                din0   <= bus.cmd_we ? bus.cmd_wdata : '0;
            end else begin
                csb0   <= 1'b1;
                web0   <= 1'b1;
                wmask0 <= '0;
                addr0  <= '0;
                din0   <= '0;
            end
        end
    end

    sram_1rw1r_initiator_fifo2 #(.WIDTH(DATA_WIDTH)) u_rsp_fifo (
        .clk0 (clk0), .rst0 (rst0), .push (rd0_s2), .din (dout0),
        .pop  (rsp_pop), .count (rsp_count), .dout (rsp_dout)
    );

`ifdef SRAM_INITIATOR_COLLISION_STALL_EN
    assign collide = cmd_fire & bus.cmd_we & (bus.cmd_addr == scan_addr);
`else
    assign collide = 1'b0;
`endif

    assign eff_len        = (bus.scan_len == '0) ? LEN_ONE : bus.scan_len;
    assign credit1        = {2'b00, rd1_s1} + {2'b00, rd1_s2} + {1'b0, scan_count};
    assign scan_issue     = (state == S_RUN) && (credit1 < 3'd2) && !collide;
    assign bus.scan_valid = (scan_count != 2'd0);
    assign bus.scan_data  = scan_dout;
    assign bus.scan_busy  = (state != S_IDLE);
    assign bus.scan_done  = scan_done_q;
    assign scan_pop       = bus.scan_valid & bus.scan_ready;

    // accept_left counts words not yet taken by the consumer; DRAIN ends on the last one.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state       <= S_IDLE;
            scan_addr   <= '0;
            issue_left  <= '0;
            accept_left <= '0;
            scan_done_q <= 1'b0;
            csb1        <= 1'b1;
            addr1       <= '0;
            rd1_s1      <= 1'b0;
            rd1_s2      <= 1'b0;
        end else begin
            scan_done_q <= 1'b0;
            rd1_s1      <= scan_issue;
            rd1_s2      <= rd1_s1;
            csb1        <= ~scan_issue;
            addr1       <= scan_issue ? scan_addr : '0;
            if (scan_pop) accept_left <= accept_left - LEN_ONE;
            case (state)
                S_IDLE: begin
                    if (bus.scan_start) begin
                        scan_addr   <= bus.scan_base;
                        issue_left  <= eff_len;
                        accept_left <= eff_len;
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (scan_issue) begin
                        scan_addr  <= scan_addr + ADDR_ONE;
                        issue_left <= issue_left - LEN_ONE;
                        if (issue_left == LEN_ONE) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (scan_pop && (accept_left == LEN_ONE)) begin
                        state       <= S_IDLE;
                        scan_done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    sram_1rw1r_initiator_fifo2 #(.WIDTH(DATA_WIDTH)) u_scan_fifo (
        .clk0 (clk0), .rst0 (rst0), .push (rd1_s2), .din (dout1),
        .pop  (scan_pop), .count (scan_count), .dout (scan_dout)
    );
endmodule

// File: tb/tb_sram_1rw1r_initiator.sv
// Self-checking bench for sram_1rw1r_initiator with a behavioural 1rw1r macro model and
// scoreboard queues; the collision scenario is built only with SRAM_INITIATOR_COLLISION_STALL_EN.
module tb_sram_1rw1r_initiator;
    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int NW    = 1;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [NW-1:0] mask;
    } op_t;

    logic          clk0 = 1'b0;
    logic          rst0 = 1'b1;
    logic          csb0, web0, csb1;
    logic [NW-1:0] wmask0;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0 = '0;
    logic [DW-1:0] dout1 = '0;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] rsp_q[$];
    logic [DW-1:0] scan_q[$];
    int            vectors     = 0;
    int            miscompares = 0;

    sram_1rw1r_initiator_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW)) bus ();

    sram_1rw1r_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW)) dut (
        .clk0 (clk0), .rst0 (rst0), .bus (bus),
        .csb0 (csb0), .web0 (web0), .wmask0 (wmask0), .addr0 (addr0), .din0 (din0),
        .dout0 (dout0), .csb1 (csb1), .addr1 (addr1), .dout1 (dout1)
    );

    always #5 clk0 = ~clk0;

    // Macro model: inputs sampled at the edge, read data visible for the following edge.
    always @(posedge clk0) begin
        if (!csb0 && !web0 && wmask0[0]) mem[addr0] <= din0;
        if (!csb0 && web0) dout0 <= mem[addr0];
        if (!csb1) dout1 <= mem[addr1];
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(posedge clk0);
        #1;
    endtask

    function automatic op_t mk(input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [NW-1:0] m);
        op_t o;
        o.we = we; o.addr = a; o.data = d; o.mask = m;
        return o;
    endfunction

    task automatic drive_op(input op_t o);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = o.we;
        bus.cmd_addr  = o.addr;
        bus.cmd_wdata = o.data;
        bus.cmd_wmask = o.mask;
    endtask

    task automatic test_reset;
        rst0 = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({bus.rsp_valid, bus.scan_valid, bus.scan_busy, bus.scan_done,
             bus.cmd_ready, csb0, csb1, web0} !== 8'b0000_1111) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b want 00001111",
                     {bus.rsp_valid, bus.scan_valid, bus.scan_busy, bus.scan_done,
                      bus.cmd_ready, csb0, csb1, web0});
        end
        vectors++;
        if ({bus.rsp_rdata, bus.scan_data} !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h want 0000", {bus.rsp_rdata, bus.scan_data});
        end
        vectors++;
        if ({addr0, addr1, din0, wmask0} !== 29'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_drive: got %h want 0", {addr0, addr1, din0, wmask0});
        end
        rst0 = 1'b0;
        tick();
    endtask

    task automatic test_write_read;
        drive_op(mk(1'b1, 10'h005, 8'hA5, 1'b1));
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wr_ready: got %b want 1", bus.cmd_ready);
        end
        tick();
        ref_mem[10'h005] = 8'hA5;
        bus.cmd_valid = 1'b0;
        vectors++;
        if ({csb0, web0, addr0, din0, wmask0} !== {1'b0, 1'b0, 10'h005, 8'hA5, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL wr_drive: got csb0=%b web0=%b addr0=%h din0=%h wmask0=%b want 0 0 005 a5 1",
                     csb0, web0, addr0, din0, wmask0);
        end
        tick();
        drive_op(mk(1'b0, 10'h005, 8'h00, 1'b0));
        rsp_q.push_back(ref_mem[10'h005]);
        tick();
        bus.cmd_valid = 1'b0;
        vectors++;
        if ({csb0, web0, addr0, bus.rsp_valid} !== {1'b0, 1'b1, 10'h005, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL rd_drive: got csb0=%b web0=%b addr0=%h rsp_valid=%b want 0 1 005 0",
                     csb0, web0, addr0, bus.rsp_valid);
        end
        tick();
        vectors++;
        if (bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rd_latency_early: rsp_valid got %b want 0", bus.rsp_valid);
        end
        tick();
        vectors++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rsp_q[0]) begin
            miscompares++;
            $display("[TB] FAIL rd_data: got valid=%b data=%h want valid=1 data=%h",
                     bus.rsp_valid, bus.rsp_rdata, rsp_q[0]);
        end
        void'(rsp_q.pop_front());
        tick();
        vectors++;
        if (bus.rsp_valid !== 1'b0 || csb0 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rd_after_pop: got valid=%b csb0=%b want 0 1", bus.rsp_valid, csb0);
        end
    endtask

    task automatic test_stream;
        op_t ops[$];
        int  idx;
        bit  fire;
        for (int i = 0; i < 4; i++)
            ops.push_back(mk(1'b1, 10'h030 + AW'(i), DW'($urandom), 1'b1));
        ops.push_back(mk(1'b1, 10'h030, 8'hFF, 1'b0));
        ops.push_back(mk(1'b1, 10'h3FF, DW'($urandom), 1'b1));
        ops.push_back(mk(1'b0, 10'h033, 8'h00, 1'b0));
        ops.push_back(mk(1'b0, 10'h030, 8'h00, 1'b0));
        ops.push_back(mk(1'b0, 10'h031, 8'h00, 1'b0));
        ops.push_back(mk(1'b0, 10'h032, 8'h00, 1'b0));
        ops.push_back(mk(1'b0, 10'h005, 8'h00, 1'b0));
        ops.push_back(mk(1'b0, 10'h3FF, 8'h00, 1'b0));
        ops.push_back(mk(1'b0, 10'h000, 8'h00, 1'b0));
        ops.push_back(mk(1'b1, 10'h031, 8'h5A, 1'b1));
        ops.push_back(mk(1'b0, 10'h031, 8'h00, 1'b0));
        idx = 0;
        drive_op(ops[0]);
        bus.rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                vectors++;
                if (rsp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL stream_extra: got data=%h want no response", bus.rsp_rdata);
                end else if (bus.rsp_rdata !== rsp_q[0]) begin
                    miscompares++;
                    $display("[TB] FAIL stream_rdata: got %h want %h", bus.rsp_rdata, rsp_q[0]);
                end
                if (rsp_q.size() != 0) void'(rsp_q.pop_front());
            end
            fire = bus.cmd_valid && bus.cmd_ready;
            if (fire) begin
                if (ops[idx].we) begin
                    if (ops[idx].mask[0]) ref_mem[ops[idx].addr] = ops[idx].data;
                end else begin
                    rsp_q.push_back(ref_mem[ops[idx].addr]);
                end
            end
            tick();
            if (fire) begin
                idx++;
                if (idx < ops.size()) drive_op(ops[idx]);
                else bus.cmd_valid = 1'b0;
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            if (idx == ops.size() && rsp_q.size() == 0) break;
        end
        bus.rsp_ready = 1'b1;
        vectors++;
        if (idx != ops.size() || rsp_q.size() != 0 || bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stream_complete: got issued=%0d pending=%0d rsp_valid=%b want %0d 0 0",
                     idx, rsp_q.size(), bus.rsp_valid, ops.size());
        end
        rsp_q.delete();
    endtask

    task automatic test_backpressure;
        int accepted;
        int idx;
        bit fire;
        accepted = 0;
        idx = 0;
        bus.rsp_ready = 1'b0;
        drive_op(mk(1'b0, 10'h040, 8'h00, 1'b0));
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc == 8) begin
                vectors++;
                if (accepted != 2 || bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL bp_stall: got accepted=%0d cmd_ready=%b rsp_valid=%b want 2 0 1",
                             accepted, bus.cmd_ready, bus.rsp_valid);
                end
                bus.rsp_ready = 1'b1;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                vectors++;
                if (rsp_q.size() == 0 || bus.rsp_rdata !== rsp_q[0]) begin
                    miscompares++;
                    $display("[TB] FAIL bp_rdata: got %h want %h (pending %0d)",
                             bus.rsp_rdata, (rsp_q.size() != 0) ? rsp_q[0] : 8'h00, rsp_q.size());
                end
                if (rsp_q.size() != 0) void'(rsp_q.pop_front());
            end
            fire = bus.cmd_valid && bus.cmd_ready;
            if (fire) begin
                rsp_q.push_back(ref_mem[bus.cmd_addr]);
                accepted++;
            end
            tick();
            if (fire) begin
                idx++;
                if (idx < 4) drive_op(mk(1'b0, 10'h040 + AW'(idx), 8'h00, 1'b0));
                else bus.cmd_valid = 1'b0;
            end
            if (cyc > 8 && idx == 4 && rsp_q.size() == 0) break;
        end
        vectors++;
        if (accepted != 4 || rsp_q.size() != 0 || bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_complete: got accepted=%0d pending=%0d rsp_valid=%b want 4 0 0",
                     accepted, rsp_q.size(), bus.rsp_valid);
        end
        rsp_q.delete();
    endtask

    task automatic test_scan(input logic [AW-1:0] base, input logic [AW:0] len, input bit rnd);
        int            n;
        int            done_cnt;
        int            first_valid;
        logic [AW-1:0] a;
        n = (len == '0) ? 1 : int'(len);
        done_cnt = 0;
        first_valid = -1;
        a = base;
        for (int i = 0; i < n; i++) begin
            scan_q.push_back(ref_mem[a]);
            a = a + 1'b1;
        end
        bus.scan_base  = base;
        bus.scan_len   = len;
        bus.scan_ready = 1'b1;
        bus.scan_start = 1'b1;
        tick();
        bus.scan_start = 1'b0;
        vectors++;
        if (bus.scan_busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL scan_busy_start: got %b want 1", bus.scan_busy);
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc == 1) begin
                vectors++;
                if (csb1 !== 1'b0 || addr1 !== base) begin
                    miscompares++;
                    $display("[TB] FAIL scan_first_issue: got csb1=%b addr1=%h want 0 %h", csb1, addr1, base);
                end
                bus.scan_base  = base ^ 10'h155;
                bus.scan_start = 1'b1;
            end
            if (bus.scan_valid && first_valid < 0) first_valid = cyc;
            if (bus.scan_done) begin
                done_cnt++;
                vectors++;
                if (scan_q.size() != 0) begin
                    miscompares++;
                    $display("[TB] FAIL scan_done_early: got %0d words pending want 0", scan_q.size());
                end
            end
            if (bus.scan_valid && bus.scan_ready) begin
                vectors++;
                if (scan_q.size() == 0 || bus.scan_data !== scan_q[0]) begin
                    miscompares++;
                    $display("[TB] FAIL scan_data: base=%h got %h want %h (pending %0d)", base,
                             bus.scan_data, (scan_q.size() != 0) ? scan_q[0] : 8'h00, scan_q.size());
                end
                if (scan_q.size() != 0) void'(scan_q.pop_front());
            end
            if (cyc > 0 && !bus.scan_busy) break;
            tick();
            bus.scan_start = 1'b0;
            bus.scan_base  = base;
            bus.scan_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        vectors++;
        if (first_valid != 3) begin
            miscompares++;
            $display("[TB] FAIL scan_latency: got first scan_valid at cycle %0d want 3", first_valid);
        end
        vectors++;
        if (done_cnt != 1 || scan_q.size() != 0 || bus.scan_busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL scan_complete: got done=%0d pending=%0d busy=%b want 1 0 0",
                     done_cnt, scan_q.size(), bus.scan_busy);
        end
        bus.scan_ready = 1'b1;
        tick();
        vectors++;
        if (bus.scan_done !== 1'b0 || bus.scan_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL scan_done_pulse: got done=%b valid=%b want 0 0", bus.scan_done, bus.scan_valid);
        end
        scan_q.delete();
    endtask

`ifdef SRAM_INITIATOR_COLLISION_STALL_EN
    task automatic test_collision;
        bus.scan_base  = 10'h010;
        bus.scan_len   = 11'd1;
        bus.scan_ready = 1'b1;
        bus.scan_start = 1'b1;
        tick();
        bus.scan_start = 1'b0;
        drive_op(mk(1'b1, 10'h010, 8'h3C, 1'b1));
        ref_mem[10'h010] = 8'h3C;
        scan_q.push_back(ref_mem[10'h010]);
        tick();
        bus.cmd_valid = 1'b0;
        vectors++;
        if ({csb1, csb0, web0} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL coll_hold: got csb1=%b csb0=%b web0=%b want 1 0 0", csb1, csb0, web0);
        end
        tick();
        vectors++;
        if (csb1 !== 1'b0 || addr1 !== 10'h010) begin
            miscompares++;
            $display("[TB] FAIL coll_issue: got csb1=%b addr1=%h want 0 010", csb1, addr1);
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (bus.scan_valid) begin
                vectors++;
                if (scan_q.size() == 0 || bus.scan_data !== scan_q[0]) begin
                    miscompares++;
                    $display("[TB] FAIL coll_data: got %h want 3c", bus.scan_data);
                end
                if (scan_q.size() != 0) void'(scan_q.pop_front());
            end
            if (!bus.scan_busy) break;
            tick();
        end
        vectors++;
        if (scan_q.size() != 0 || bus.scan_busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL coll_complete: got pending=%0d busy=%b want 0 0", scan_q.size(), bus.scan_busy);
        end
        scan_q.delete();
        tick();
    endtask
`endif

    task automatic test_reset_midscan;
        int stray;
        stray = 0;
        bus.scan_ready = 1'b0;
        bus.rsp_ready  = 1'b0;
        drive_op(mk(1'b0, 10'h050, 8'h00, 1'b0));
        tick();
        bus.cmd_valid  = 1'b0;
        bus.scan_base  = 10'h100;
        bus.scan_len   = 11'd8;
        bus.scan_start = 1'b1;
        tick();
        bus.scan_start = 1'b0;
        repeat (5) tick();
        vectors++;
        if ({bus.rsp_valid, bus.scan_valid, bus.scan_busy} !== 3'b111) begin
            miscompares++;
            $display("[TB] FAIL midscan_pending: got rsp_valid,scan_valid,busy=%b want 111",
                     {bus.rsp_valid, bus.scan_valid, bus.scan_busy});
        end
        #2 rst0 = 1'b1;
        #1;
        vectors++;
        if ({bus.rsp_valid, bus.scan_valid, bus.scan_busy, bus.scan_done,
             bus.cmd_ready, csb0, csb1} !== 7'b0000111) begin
            miscompares++;
            $display("[TB] FAIL midscan_reset: got %b want 0000111",
                     {bus.rsp_valid, bus.scan_valid, bus.scan_busy, bus.scan_done,
                      bus.cmd_ready, csb0, csb1});
        end
        repeat (2) begin
            tick();
            if (bus.scan_done) stray++;
        end
        rst0 = 1'b0;
        bus.scan_ready = 1'b1;
        bus.rsp_ready  = 1'b1;
        repeat (6) begin
            tick();
            if (bus.scan_done || bus.scan_valid || bus.rsp_valid || !csb1) stray++;
        end
        vectors++;
        if (stray != 0) begin
            miscompares++;
            $display("[TB] FAIL midscan_aftermath: got %0d stray outputs want 0", stray);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = DW'(i * 37 + 11);
            ref_mem[i] = DW'(i * 37 + 11);
        end
        bus.cmd_valid  = 1'b0;
        bus.cmd_we     = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_wdata  = '0;
        bus.cmd_wmask  = '0;
        bus.rsp_ready  = 1'b1;
        bus.scan_start = 1'b0;
        bus.scan_base  = '0;
        bus.scan_len   = '0;
        bus.scan_ready = 1'b1;

        test_reset();
        test_write_read();
        test_stream();
        test_backpressure();
        test_scan(10'h3FE, 11'd4, 1'b0);
        test_scan(10'h123, 11'd0, 1'b0);
        test_scan(10'h040, 11'd9, 1'b1);
`ifdef SRAM_INITIATOR_COLLISION_STALL_EN
        test_collision();
`endif
        test_reset_midscan();
        test_scan(10'h200, 11'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
